cordic_pipe_core: RTL and testbench

CORDIC_PIPE_CORE -- requirements
Module: cordic_pipe_core

---
 rtl/cordic_pipe_core.sv | 153 +++++++++++++++
 tb/tb_cordic_pipe_core.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_pipe_core.sv
// Pipelined CORDIC core: rotation/vectoring per sample, stall by global advance enable.
// Optional macro CORDIC_GAIN_COMP_EN scales out_x/out_y by the inverse CORDIC gain.
module cordic_pipe_stage #(
   parameter int DATA_W = 32,
   parameter int SHIFT = 0,
   parameter logic [DATA_W-1:0] ATAN = '0
) (
   input  logic              clk,
   input  logic              RST_N,
   input  logic              ce,
   input  logic              vld,
   input  logic              mode,
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   input  logic [DATA_W-1:0] z,
   output logic              vld_q,
   output logic              mode_q,
   output logic [DATA_W-1:0] x_q,
   output logic [DATA_W-1:0] y_q,
   output logic [DATA_W-1:0] z_q
);
   logic [DATA_W-1:0] xs, ys;
   logic              pos;

   assign xs  = $signed(x) >>> SHIFT;
   assign ys  = $signed(y) >>> SHIFT;
   // Rotation drives z toward zero, vectoring drives y toward zero.
   assign pos = mode ? y[DATA_W-1] : ~z[DATA_W-1];

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         vld_q  <= 1'b0;
         mode_q <= 1'b0;
         x_q    <= '0;
         y_q    <= '0;
         z_q    <= '0;
      end else if (ce) begin
         vld_q  <= vld;
         mode_q <= mode;
         if (pos) begin
            x_q <= x - ys;
            y_q <= y + xs;
            z_q <= z - ATAN;
         end else begin
            x_q <= x + ys;
            y_q <= y - xs;
            z_q <= z + ATAN;
         end
      end
   end
endmodule

module cordic_pipe_core #(
   parameter int DATA_W = 32,
   parameter int FRAC_W = 16,
   parameter int STAGES = 16
) (
   input  logic              clk,
   input  logic              RST_N,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_mode,
   input  logic [DATA_W-1:0] in_x,
   input  logic [DATA_W-1:0] in_y,
   input  logic [DATA_W-1:0] in_z,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_x,
   output logic [DATA_W-1:0] out_y,
   output logic [DATA_W-1:0] out_z,
   output logic              out_mode
);
   function automatic logic [DATA_W-1:0] atan_q(input int i);
      real a;
      a = $atan(2.0 ** (-i)) * (2.0 ** FRAC_W);
      return DATA_W'(longint'(a));
   endfunction

   logic                         ce;
   logic [STAGES:0]              vld_pipe, mode_pipe;
   logic [STAGES:0][DATA_W-1:0]  x_pipe, y_pipe, z_pipe;
   logic [DATA_W-1:0]            x_fin, y_fin;

   assign ce       = ~out_valid | out_ready;
   assign in_ready = ce;

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         vld_pipe[0]  <= 1'b0;
         mode_pipe[0] <= 1'b0;
         x_pipe[0]    <= '0;
         y_pipe[0]    <= '0;
         z_pipe[0]    <= '0;
      end else if (ce) begin
         vld_pipe[0]  <= in_valid;
         mode_pipe[0] <= in_mode;
         x_pipe[0]    <= in_x;
         y_pipe[0]    <= in_y;
         z_pipe[0]    <= in_z;
      end
   end

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      cordic_pipe_stage #(
         .DATA_W (DATA_W),
         .SHIFT  (i),
         .ATAN   (atan_q(i))
      ) u_stage (
         .clk    (clk),
         .RST_N  (RST_N),
         .ce     (ce),
         .vld    (vld_pipe[i]),
         .mode   (mode_pipe[i]),
         .x      (x_pipe[i]),
         .y      (y_pipe[i]),
         .z      (z_pipe[i]),
         .vld_q  (vld_pipe[i+1]),
         .mode_q (mode_pipe[i+1]),
         .x_q    (x_pipe[i+1]),
         .y_q    (y_pipe[i+1]),
         .z_q    (z_pipe[i+1])
      );
   end

`ifdef CORDIC_GAIN_COMP_EN
   localparam logic [DATA_W-1:0] K_Q = DATA_W'(longint'(0.6072529 * (2.0 ** FRAC_W)));
   logic [DATA_W+FRAC_W-1:0] px, py;
   // Truncating fixed-point multiply: keep product bits [DATA_W+FRAC_W-1:FRAC_W].
   assign px    = {{FRAC_W{x_pipe[STAGES][DATA_W-1]}}, x_pipe[STAGES]} * {{FRAC_W{1'b0}}, K_Q};
   assign py    = {{FRAC_W{y_pipe[STAGES][DATA_W-1]}}, y_pipe[STAGES]} * {{FRAC_W{1'b0}}, K_Q};
   assign x_fin = DATA_W'(px >> FRAC_W);
   assign y_fin = DATA_W'(py >> FRAC_W);
`else
   assign x_fin = x_pipe[STAGES];
   assign y_fin = y_pipe[STAGES];
`endif

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         out_valid <= 1'b0;
         out_mode  <= 1'b0;
         out_x     <= '0;
         out_y     <= '0;
         out_z     <= '0;
      end else if (ce) begin
         out_valid <= vld_pipe[STAGES];
         out_mode  <= mode_pipe[STAGES];
         out_x     <= x_fin;
         out_y     <= y_fin;
         out_z     <= z_pipe[STAGES];
      end
   end
endmodule

// File: tb/tb_cordic_pipe_core.sv
// Scoreboard bench for cordic_pipe_core: bit-exact CORDIC model plus real-math spot checks.
module tb_cordic_pipe_core;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          RST_N;
   logic          in_valid, in_ready, in_mode;
   logic [DW-1:0] in_x, in_y, in_z;
   logic          out_valid, out_ready, out_mode;
   logic [DW-1:0] out_x, out_y, out_z;

   cordic_pipe_core #(.DATA_W(32), .FRAC_W(16), .STAGES(16)) dut (
      .clk(clk), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_x(in_x), .in_y(in_y), .in_z(in_z), .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_mode(out_mode)
   );

   always #5 clk = ~clk;

   typedef struct { int x; int y; int z; bit m; } exp_t;
   exp_t   sb[$];
   int     atan_t[16];
   int     n_vec = 0, n_err = 0, n_out = 0;
`ifdef CORDIC_GAIN_COMP_EN
   real    G = 1.0;
`else
   real    G = 1.64676;
`endif

   task automatic chk(input string tag, input longint got, input longint exp, input longint tol = 0);
      n_vec++;
      if (got - exp > tol || exp - got > tol) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
      end
   endtask

   function automatic exp_t model(input bit m, input int x0, input int y0, input int z0);
      exp_t r;
      int x = x0, y = y0, z = z0, xs, ys;
      bit pos;
      for (int i = 0; i < 16; i++) begin
         pos = m ? (y < 0) : (z >= 0);
         xs = x >>> i;
         ys = y >>> i;
         if (pos) begin x = x - ys; y = y + xs; z = z - atan_t[i]; end
         else     begin x = x + ys; y = y - xs; z = z + atan_t[i]; end
      end
`ifdef CORDIC_GAIN_COMP_EN
      r.x = int'((longint'(x) * 39797) >>> 16);
      r.y = int'((longint'(y) * 39797) >>> 16);
`else
      r.x = x;
      r.y = y;
`endif
      r.z = z;
      r.m = m;
      return r;
   endfunction

   // Transfers are judged mid-cycle, where handshakes are stable for the coming edge.
   always @(negedge clk) begin
      exp_t e;
      if (!RST_N) sb.delete();
      else begin
         if (in_valid && in_ready) sb.push_back(model(in_mode, $signed(in_x), $signed(in_y), $signed(in_z)));
         if (out_valid && out_ready) begin
            chk("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               n_out++;
               chk("sb_x", $signed(out_x), e.x);
               chk("sb_y", $signed(out_y), e.y);
               chk("sb_z", $signed(out_z), e.z);
               chk("sb_mode", out_mode, e.m);
            end
         end
      end
   end

   task automatic send(input bit m, input int x, input int y, input int z);
      bit acc = 0;
      in_valid = 1; in_mode = m; in_x = x; in_y = y; in_z = z;
      for (int n = 0; n < 100 && !acc; n++) begin
         @(negedge clk); acc = in_ready;
         @(posedge clk); #1;
      end
      in_valid = 0;
      chk("send_accepted", acc, 1);
   endtask

   function automatic int srnd(input int lim);
      return int'($urandom_range(0, 2 * lim)) - lim;
   endfunction

   task automatic send_rand(input bit m);
      if (m) send(1, int'($urandom_range(0, 1 << 20)), srnd(1 << 20), 0);
      else   send(0, srnd(1 << 20), srnd(1 << 20), srnd(114000));
   endtask

   task automatic lat_test(input string tag);
      int n = 0;
      in_valid = 1; in_mode = 0; in_x = 32'h10000; in_y = 0; in_z = 0;
      do begin
         @(posedge clk); n++; #1;
         in_valid = 0;
      end while (!out_valid && n < 40);
      chk(tag, n, 18);
      @(posedge clk); #1;
      chk({tag, "_one_cycle"}, out_valid, 0);
   endtask

   task automatic spot(input string tag, input bit m, input int x, input int y, input int z,
                       input real ex, input real ey, input real ez);
      int n = 0;
      longint tol = longint'(16.0 * G);
      send(m, x, y, z);
      while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_x"}, $signed(out_x), longint'(ex), tol);
      chk({tag, "_y"}, $signed(out_y), longint'(ey), tol);
      chk({tag, "_z"}, $signed(out_z), longint'(ez), 16);
      chk({tag, "_mode"}, out_mode, m);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (sb.size() > 0 && n < 300) begin @(posedge clk); #1; n++; end
      chk(tag, sb.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int base, ov_seen;
      logic [DW-1:0] hx, hy, hz;
      real zr;
      for (int i = 0; i < 16; i++) atan_t[i] = int'($floor($atan(2.0 ** (-i)) * 65536.0 + 0.5));
      RST_N = 0; in_valid = 0; in_mode = 0; in_x = 0; in_y = 0; in_z = 0; out_ready = 1;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_x", out_x, 0);
      chk("rst_out_y", out_y, 0);
      chk("rst_out_z", out_z, 0);
      chk("rst_out_mode", out_mode, 0);
      @(posedge clk); #1 RST_N = 1;
      repeat (2) @(posedge clk); #1;

      lat_test("latency");

      zr = real'(32'h860B) / 65536.0;
      spot("vec34", 1, 32'h30000, 32'h40000, 0, 5.0 * G * 65536.0, 0.0, $atan2(4.0, 3.0) * 65536.0);
      spot("rot30", 0, 32'h10000, 0, 32'h860B, $cos(zr) * G * 65536.0, $sin(zr) * G * 65536.0, 0.0);
      spot("rotm30", 0, 32'h10000, 0, -32'sh860B, $cos(zr) * G * 65536.0, -$sin(zr) * G * 65536.0, 0.0);
      spot("rot0", 0, 32'h10000, 0, 0, G * 65536.0, 0.0, 0.0);
      drain("drain_spot");

      // 40-sample stream with a 5-cycle downstream stall in the middle
      base = n_out;
      fork
         for (int k = 0; k < 40; k++) send_rand(k[0]);
         begin
            repeat (25) @(posedge clk);
            #1 out_ready = 0;
            hx = out_x; hy = out_y; hz = out_z;
            repeat (5) begin
               @(negedge clk);
               chk("stall_in_ready", in_ready, 0);
               chk("stall_out_valid", out_valid, 1);
               chk("stall_hold_x", out_x, hx);
               chk("stall_hold_y", out_y, hy);
               chk("stall_hold_z", out_z, hz);
               @(posedge clk);
            end
            #1 out_ready = 1;
         end
      join
      drain("drain_stream");
      chk("stream_count", n_out - base, 40);

      // random valid gaps and random backpressure
      base = n_out;
      fork
         for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            send_rand(1'($urandom_range(0, 1)));
         end
         begin
            repeat (150) begin @(posedge clk); #1 out_ready = ($urandom_range(0, 2) != 0); end
            out_ready = 1;
         end
      join
      drain("drain_rand");
      chk("rand_count", n_out - base, 60);

      // reset with samples in flight
      for (int k = 0; k < 24; k++) send_rand(1);
      chk("pre_rst_out_valid", out_valid, 1);
      #1 RST_N = 0;
      #1;
      chk("rst_mid_out_valid", out_valid, 0);
      chk("rst_mid_in_ready", in_ready, 1);
      chk("rst_mid_out_x", out_x, 0);
      chk("rst_mid_out_mode", out_mode, 0);
      repeat (2) @(posedge clk);
      #1 RST_N = 1;
      ov_seen = 0;
      repeat (25) begin @(negedge clk); if (out_valid) ov_seen++; end
      chk("no_stale_after_rst", ov_seen, 0);
      @(posedge clk); #1;
      lat_test("latency_after_rst");
      drain("drain_final");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
